// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states,
// default operand width and the iteration counter width.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH = 32;

  // One extra bit so the counter can hold the value WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor and keep or restore the partial remainder.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted_s;
  logic [WIDTH+1:0] diff_s;

  // Trial subtraction; the extra top bit of diff_s is the borrow/sign.
  always_comb begin
    shifted_s = {rem_in, bit_in};
    diff_s    = shifted_s - {2'b00, divisor};
    q_bit     = ~diff_s[WIDTH+1];
    if (q_bit) begin
      rem_out = diff_s[WIDTH:0];
    end else begin
      rem_out = shifted_s[WIDTH:0];
    end
  end

endmodule

// File: rtl/div_32bit_seq.sv
// Sequential restoring divider, one quotient bit per cycle, WIDTH+1 cycle latency.
// Optional signed (MIPS div) mode is enabled by defining DIV_SIGNED_EN.
module div_32bit_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);

  div_state_t       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dsr_r;
  logic             neg_q_r;
  logic             neg_rem_r;

  logic [WIDTH-1:0] op_a_s;
  logic [WIDTH-1:0] op_b_s;
  logic             neg_q_s;
  logic             neg_rem_s;
  logic [WIDTH:0]   step_rem_s;
  logic             step_q_s;

`ifndef DIV_SIGNED_EN
  logic signed_op_unused_s;
  assign signed_op_unused_s = signed_op;
`endif

  // Operand magnitudes and result sign fix-ups captured at start.
  always_comb begin
    op_a_s    = dividend;
    op_b_s    = divisor;
    neg_q_s   = 1'b0;
    neg_rem_s = 1'b0;
`ifdef DIV_SIGNED_EN
    if (signed_op) begin
      neg_q_s   = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_rem_s = dividend[WIDTH-1];
      op_a_s    = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
      op_b_s    = divisor[WIDTH-1]  ? (~divisor + WIDTH'(1))  : divisor;
    end else begin
      op_a_s    = dividend;
      op_b_s    = divisor;
      neg_q_s   = 1'b0;
      neg_rem_s = 1'b0;
    end
`endif
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_r),
    .bit_in  (quo_r[WIDTH-1]),
    .divisor (dsr_r),
    .rem_out (step_rem_s),
    .q_bit   (step_q_s)
  );

  // Control FSM, working registers and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      dsr_r       <= '0;
      neg_q_r     <= 1'b0;
      neg_rem_r   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start && (divisor == '0)) begin
            state_r     <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
          end else if (start) begin
            state_r     <= RUN;
            cnt_r       <= '0;
            rem_r       <= '0;
            quo_r       <= op_a_s;
            dsr_r       <= op_b_s;
            neg_q_r     <= neg_q_s;
            neg_rem_r   <= neg_rem_s;
            busy        <= 1'b1;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
          end else begin
            state_r <= IDLE;
            done    <= 1'b0;
          end
        end
        RUN: begin
          if (cnt_r == CNT_W'(WIDTH)) begin
            // Extra cycle after the last iteration applies the sign fix-up.
            state_r   <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= neg_q_r ? (~quo_r + WIDTH'(1)) : quo_r;
            remainder <= neg_rem_r ? (~rem_r[WIDTH-1:0] + WIDTH'(1)) : rem_r[WIDTH-1:0];
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
            rem_r <= step_rem_s;
            quo_r <= {quo_r[WIDTH-2:0], step_q_s};
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_32bit_seq.sv
// Directed self-checking bench for div_32bit_seq; signed vectors run when
// DIV_SIGNED_EN is defined, otherwise signed_op is checked to be ignored.
module tb_div_32bit_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  div_32bit_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present operands with start for one accepting edge, then sample #1 later.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic sg);
    dividend  = a;
    divisor   = b;
    signed_op = sg;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges after the accepting edge until done; optionally re-pulse start.
  task automatic wait_done(input int inj_at, output int cyc);
    cyc = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cyc = i;
        break;
      end
      if (i == inj_at) begin
        start    = 1'b1;
        dividend = 32'd5;
        divisor  = 32'd1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int cyc;
    int n_done;
    rst_n     = 1'b0;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = 32'd0;
    divisor   = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 100 / 7 unsigned
    launch(32'd100, 32'd7, 1'b0);
    check("t1_busy", {31'd0, busy}, 32'd1);
    wait_done(0, cyc);
    check("t1_lat", cyc, 32'd33);
    check("t1_busy_at_done", {31'd0, busy}, 32'd0);
    check("t1_q", quotient, 32'd14);
    check("t1_r", remainder, 32'd2);
    check("t1_dbz", {31'd0, div_by_zero}, 32'd0);
    @(posedge clk);
    #1;
    check("t1_done_pulse", {31'd0, done}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t1_hold_q", quotient, 32'd14);

    // divide by zero
    launch(32'h1234_5678, 32'd0, 1'b0);
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_busy", {31'd0, busy}, 32'd0);
    check("t2_q", quotient, 32'hFFFF_FFFF);
    check("t2_r", remainder, 32'h1234_5678);
    check("t2_dbz", {31'd0, div_by_zero}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("t2_dbz_hold", {31'd0, div_by_zero}, 32'd1);
    check("t2_done_low", {31'd0, done}, 32'd0);

    // max / 1, then back-to-back 9 / 3 started in the DONE cycle
    launch(32'hFFFF_FFFF, 32'd1, 1'b0);
    check("t3_dbz_cleared", {31'd0, div_by_zero}, 32'd0);
    wait_done(0, cyc);
    check("t3_lat", cyc, 32'd33);
    check("t3_q", quotient, 32'hFFFF_FFFF);
    check("t3_r", remainder, 32'd0);
    launch(32'd9, 32'd3, 1'b0);
    check("t3b_busy", {31'd0, busy}, 32'd1);
    check("t3b_done_low", {31'd0, done}, 32'd0);
    wait_done(0, cyc);
    check("t3b_lat", cyc, 32'd33);
    check("t3b_q", quotient, 32'd3);
    check("t3b_r", remainder, 32'd0);

`ifdef DIV_SIGNED_EN
    launch(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done(0, cyc);
    check("t4_lat", cyc, 32'd33);
    check("t4_q", quotient, 32'hFFFF_FFFD);
    check("t4_r", remainder, 32'hFFFF_FFFF);
    launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done(0, cyc);
    check("t4b_q", quotient, 32'h8000_0000);
    check("t4b_r", remainder, 32'd0);
`else
    // signed_op ignored: 0xFFFFFFF9 / 2 unsigned
    launch(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done(0, cyc);
    check("t4_lat", cyc, 32'd33);
    check("t4_q", quotient, 32'h7FFF_FFFC);
    check("t4_r", remainder, 32'd1);
`endif

    // start re-pulsed at cycle 10 of RUN is ignored
    launch(32'd1000, 32'd10, 1'b0);
    wait_done(10, cyc);
    check("t5_lat", cyc, 32'd33);
    check("t5_q", quotient, 32'd100);
    check("t5_r", remainder, 32'd0);

    // reset mid-RUN aborts without done
    launch(32'd100, 32'd7, 1'b0);
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_done", {31'd0, done}, 32'd0);
    check("t6_q", quotient, 32'd0);
    check("t6_r", remainder, 32'd0);
    check("t6_dbz", {31'd0, div_by_zero}, 32'd0);
    n_done = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    check("t6_no_done", n_done, 32'd0);
    launch(32'd100, 32'd7, 1'b0);
    wait_done(0, cyc);
    check("t6b_lat", cyc, 32'd33);
    check("t6b_q", quotient, 32'd14);
    check("t6b_r", remainder, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_32bit_seq.md
DIV_32BIT_SEQ -- requirements
Module: div_32bit_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request to begin a division; sampled only in IDLE or DONE.
REQ-005 SHALL have port signed_op, input, 1 bit: selects signed division; sampled with start.
REQ-006 SHALL have port dividend, input, WIDTH bits: numerator; sampled with start.
REQ-007 SHALL have port divisor, input, WIDTH bits: denominator; sampled with start.
REQ-008 SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when results become valid.
REQ-010 SHALL have port quotient, output, WIDTH bits: result quotient.
REQ-011 SHALL have port remainder, output, WIDTH bits: result remainder.
REQ-012 SHALL have port div_by_zero, output, 1 bit: high with done when divisor was 0; held until next accepted start.

Function
REQ-013 SHALL implement three states: IDLE, RUN, DONE.
REQ-014 SHALL make these transitions: IDLE or DONE to RUN on start=1; RUN to DONE after WIDTH iterations; DONE to IDLE after one cycle when start=0.
REQ-015 SHALL use restoring division in RUN, one quotient bit per cycle, MSB first: shift the partial remainder left by one, subtract the divisor, keep the result if it is non-negative, otherwise restore.
REQ-016 SHALL hold the partial remainder at WIDTH+1 bits so the subtraction cannot overflow.
REQ-017 SHALL assert done exactly WIDTH+1 cycles after the edge that accepts start: 33 cycles at the default width.
REQ-018 SHALL assert busy from the cycle after acceptance until done, and deassert busy in the same cycle done is high.
REQ-019 SHALL ignore start, and any operand changes, while busy=1.
REQ-020 SHALL accept a start in the DONE cycle, giving back-to-back operation; the new division returns to RUN.
REQ-021 SHALL handle divisor=0 as follows: skip RUN and enter DONE on the next edge; quotient = all ones; remainder = dividend; div_by_zero = 1.
REQ-022 SHALL hold quotient, remainder and div_by_zero stable from done until the next accepted start.

Reset
REQ-023 SHALL, on rst_n low and asynchronously, put the state in IDLE and drive busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
REQ-024 SHALL abort a division in progress when reset is applied mid-RUN; done SHALL NOT be produced for the aborted operation.
REQ-025 SHALL remove reset cleanly; the first start is accepted on the first rising edge after rst_n is high.

Configuration
REQ-026 SHALL, when macro DIV_SIGNED_EN is defined, honor signed_op, using the MIPS div semantics below.
- The block takes the magnitudes of both operands, runs the unsigned core, then negates the results.
- The quotient is truncated toward zero.
- The remainder takes the sign of the dividend.
- 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0.
REQ-027 SHALL, when DIV_SIGNED_EN is undefined, keep the signed_op port but ignore it; all operations are unsigned (divu).

Structure
REQ-028 SHALL place the state enumeration (IDLE/RUN/DONE), the default WIDTH constant and the iteration counter width, clog2(WIDTH)+1, in shared package div_pkg.
REQ-029 SHALL implement one restoring iteration (shift, subtract, select) as combinational sub-module div_step, instantiated once inside div_32bit_seq.

Verification
REQ-030 SHALL cover: dividend 100, divisor 7, unsigned -> done at cycle 33; quotient 14; remainder 2; div_by_zero 0.
REQ-031 SHALL cover: divisor 0, dividend 0x12345678 -> done on the next edge; quotient 0xFFFFFFFF; remainder 0x12345678; div_by_zero 1.
REQ-032 SHALL cover: dividend 0xFFFFFFFF, divisor 1 -> quotient 0xFFFFFFFF, remainder 0; then a second start issued in the DONE cycle with 9/3 -> quotient 3, remainder 0, 33 cycles later.
REQ-033 SHALL cover: with DIV_SIGNED_EN, signed_op=1, -7/2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-034 SHALL cover: start pulsed again with new operands at cycle 10 of RUN -> ignored, and the original result is returned at cycle 33.
REQ-035 SHALL cover: rst_n pulled low at cycle 15 of RUN -> all outputs 0 immediately, no done pulse, and a following 100/7 gives 14 remainder 2.
